// File: rtl/bg_arb_pkg.sv
// Shared types for the background-memory read arbiter.
// Coordinates, address, port ids and the in-flight response tag.
package bg_arb_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;

    typedef logic [9:0]        bg_x_t;
    typedef logic [8:0]        bg_y_t;
    typedef logic [ADDR_W-1:0] bg_addr_t;

    typedef enum logic [1:0] {
        PORT_DISP = 2'd0,
        PORT_G0   = 2'd1,
        PORT_G1   = 2'd2
    } port_t;

    typedef struct packed {
        port_t port;
        logic  oob;
        logic  valid;
    } rsp_tag_t;

    localparam rsp_tag_t TAG_IDLE = '{
        port:  PORT_DISP,
        oob:   1'b0,
        valid: 1'b0
    };

endpackage

// File: rtl/bg_addr_calc.sv
// Combinational (x, y) -> linear address for a 640-wide frame,
// plus the out-of-range flag.
module bg_addr_calc #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  bg_arb_pkg::bg_x_t  x,
    input  bg_arb_pkg::bg_y_t  y,
    output logic [ADDR_W-1:0]  addr,
    output logic               oob
);
    import bg_arb_pkg::*;

    // y*640 = y*512 + y*128, no multiplier
    assign addr = ADDR_W'({y, 9'b0})
                + ADDR_W'({y, 7'b0})
                + ADDR_W'(x);

    assign oob = ({22'd0, x} >= 32'(H_RES))
              || ({23'd0, y} >= 32'(V_RES));

endmodule

// File: rtl/bg_read_arbiter.sv
// Background memory read-port arbiter: display first, game ports round-robin.
// Define BG_ARB_STATS_EN to add grant/wait statistics outputs.
module bg_read_arbiter #(
    parameter int                H_RES     = 640,
    parameter int                V_RES     = 480,
    parameter int                ADDR_W    = 19,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] OOB_INDEX = '0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                disp_valid,
    input  bg_arb_pkg::bg_x_t   disp_x,
    input  bg_arb_pkg::bg_y_t   disp_y,
    output logic                disp_rsp_valid,
    output logic [DATA_W-1:0]   disp_rsp_data,
    input  logic [1:0]          g_valid,
    output logic [1:0]          g_ready,
    input  logic [1:0][9:0]     g_x,
    input  logic [1:0][8:0]     g_y,
    output logic [1:0]          g_rsp_valid,
    output logic [DATA_W-1:0]   g_rsp_data,
    output logic                g_rsp_oob,
    output logic [ADDR_W-1:0]   bg_addr,
    input  logic [DATA_W-1:0]   bg_data
`ifdef BG_ARB_STATS_EN
    ,
    output logic [1:0][15:0]    stat_g_grants,
    output logic [15:0]         stat_max_wait
`endif
);
    import bg_arb_pkg::*;

    logic              rr_ptr;
    logic [1:0]        g_win;
    logic              grant;
    port_t             sel_port;
    bg_x_t             sel_x;
    bg_y_t             sel_y;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_oob;
    rsp_tag_t          tag1;
    rsp_tag_t          tag2;
    logic [DATA_W-1:0] rd_data;

    // rr_ptr=0 prefers G0; a lone requester wins regardless
    assign g_win[0] = g_valid[0] & (~g_valid[1] | ~rr_ptr);
    assign g_win[1] = g_valid[1] & (~g_valid[0] |  rr_ptr);
    assign g_ready  = disp_valid ? 2'b00 : g_win;
    assign grant    = disp_valid | (|g_ready);

    always_comb begin
        sel_port = PORT_DISP;
        sel_x    = disp_x;
        sel_y    = disp_y;
        unique case (1'b1)
            disp_valid: ;
            g_ready[0]: begin
                sel_port = PORT_G0;
                sel_x    = g_x[0];
                sel_y    = g_y[0];
            end
            g_ready[1]: begin
                sel_port = PORT_G1;
                sel_x    = g_x[1];
                sel_y    = g_y[1];
            end
            default: ;
        endcase
    end

    bg_addr_calc #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .x    (sel_x),
        .y    (sel_y),
        .addr (sel_addr),
        .oob  (sel_oob)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr  <= 1'b0;
            bg_addr <= '0;
            tag1    <= TAG_IDLE;
            tag2    <= TAG_IDLE;
        end else begin
            tag2 <= tag1;
            tag1 <= TAG_IDLE;
            if (grant) begin
                tag1 <= '{port: sel_port, oob: sel_oob, valid: 1'b1};
                // OOB reads keep the old address; their data is replaced
                if (!sel_oob)
                    bg_addr <= sel_addr;
            end
            if (g_ready[0])
                rr_ptr <= 1'b1;
            else if (g_ready[1])
                rr_ptr <= 1'b0;
        end
    end

    assign rd_data        = tag2.oob ? OOB_INDEX : bg_data;
    assign disp_rsp_valid = tag2.valid & (tag2.port == PORT_DISP);
    assign disp_rsp_data  = rd_data;
    assign g_rsp_valid[0] = tag2.valid & (tag2.port == PORT_G0);
    assign g_rsp_valid[1] = tag2.valid & (tag2.port == PORT_G1);
    assign g_rsp_oob      = tag2.valid & tag2.oob
                          & (tag2.port != PORT_DISP);
    assign g_rsp_data     = rd_data;

`ifdef BG_ARB_STATS_EN
    logic [1:0][15:0] wait_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stat_g_grants <= '0;
            stat_max_wait <= '0;
            wait_cnt      <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (g_ready[k]) begin
                    wait_cnt[k] <= '0;
                    if (stat_g_grants[k] != 16'hFFFF)
                        stat_g_grants[k] <= stat_g_grants[k] + 16'd1;
                end else if (g_valid[k] && wait_cnt[k] != 16'hFFFF) begin
                    wait_cnt[k] <= wait_cnt[k] + 16'd1;
                end
            end
            // wait length is scored when the request is finally accepted
            if (g_ready[0] && wait_cnt[0] > stat_max_wait)
                stat_max_wait <= wait_cnt[0];
            else if (g_ready[1] && wait_cnt[1] > stat_max_wait)
                stat_max_wait <= wait_cnt[1];
        end
    end
`endif

endmodule

// File: tb/tb_bg_read_arbiter.sv
// Self-checking bench for bg_read_arbiter with a response scoreboard.
// Covers the BG_ARB_STATS_EN outputs when that macro is defined.
module tb_bg_read_arbiter;

    localparam logic [7:0] OOB_IDX = 8'h00;

    typedef struct {
        int         port;
        logic       oob;
        logic [7:0] data;
        int         stamp;
    } exp_t;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            disp_valid = 1'b0;
    logic [9:0]      disp_x = '0;
    logic [8:0]      disp_y = '0;
    logic            disp_rsp_valid;
    logic [7:0]      disp_rsp_data;
    logic [1:0]      g_valid = '0;
    logic [1:0]      g_ready;
    logic [1:0][9:0] g_x = '0;
    logic [1:0][8:0] g_y = '0;
    logic [1:0]      g_rsp_valid;
    logic [7:0]      g_rsp_data;
    logic            g_rsp_oob;
    logic [18:0]     bg_addr;
    logic [7:0]      bg_data = '0;
`ifdef BG_ARB_STATS_EN
    logic [1:0][15:0] stat_g_grants;
    logic [15:0]      stat_max_wait;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    exp_t dq[$];
    exp_t gq[$];

    always #5 Clk = ~Clk;

    bg_read_arbiter #(
        .H_RES(640), .V_RES(480), .ADDR_W(19),
        .DATA_W(8), .OOB_INDEX(OOB_IDX)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .disp_valid     (disp_valid),
        .disp_x         (disp_x),
        .disp_y         (disp_y),
        .disp_rsp_valid (disp_rsp_valid),
        .disp_rsp_data  (disp_rsp_data),
        .g_valid        (g_valid),
        .g_ready        (g_ready),
        .g_x            (g_x),
        .g_y            (g_y),
        .g_rsp_valid    (g_rsp_valid),
        .g_rsp_data     (g_rsp_data),
        .g_rsp_oob      (g_rsp_oob),
        .bg_addr        (bg_addr),
        .bg_data        (bg_data)
`ifdef BG_ARB_STATS_EN
        ,
        .stat_g_grants  (stat_g_grants),
        .stat_max_wait  (stat_max_wait)
`endif
    );

    function automatic logic [7:0] memf(input int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ {v[14:8], v[15]} ^ {5'd0, v[18:16]} ^ 8'h3C;
    endfunction

    // synchronous-read memory model
    always @(posedge Clk) bg_data <= memf(int'({13'd0, bg_addr}));
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic exp_t mk(input int port, input int x, input int y);
        exp_t e;
        e.port  = port;
        e.oob   = (x >= 640) || (y >= 480);
        e.data  = e.oob ? OOB_IDX : memf(y * 640 + x);
        e.stamp = cyc + 2;
        return e;
    endfunction

    always @(negedge Clk) begin
        exp_t e;
        logic [1:0] want_v;
        while (dq.size() > 0 && dq[0].stamp < cyc) begin
            n_chk++;
            e = dq.pop_front();
            $display("FAIL disp_missing: got none, want rsp at cyc %0d", e.stamp);
        end
        while (gq.size() > 0 && gq[0].stamp < cyc) begin
            n_chk++;
            e = gq.pop_front();
            $display("FAIL g_missing: got none, want rsp at cyc %0d", e.stamp);
        end
        if (disp_rsp_valid) begin
            n_chk++;
            if (dq.size() == 0) begin
                $display("FAIL disp_unexpected: got rsp data=%h, want none", disp_rsp_data);
            end else begin
                e = dq.pop_front();
                if (e.stamp !== cyc || disp_rsp_data !== e.data)
                    $display("FAIL disp_rsp: got data=%h cyc=%0d, want data=%h cyc=%0d",
                             disp_rsp_data, cyc, e.data, e.stamp);
                else
                    n_pass++;
            end
        end
        if (g_rsp_valid != 2'b00) begin
            n_chk++;
            if (gq.size() == 0) begin
                $display("FAIL g_unexpected: got valid=%b, want none", g_rsp_valid);
            end else begin
                e = gq.pop_front();
                want_v = (e.port == 1) ? 2'b01 : 2'b10;
                if (e.stamp !== cyc || g_rsp_valid !== want_v
                    || g_rsp_oob !== e.oob || g_rsp_data !== e.data)
                    $display("FAIL g_rsp: got v=%b oob=%b d=%h cyc=%0d, want v=%b oob=%b d=%h cyc=%0d",
                             g_rsp_valid, g_rsp_oob, g_rsp_data, cyc,
                             want_v, e.oob, e.data, e.stamp);
                else
                    n_pass++;
            end
        end
        if (Reset) begin
            dq.delete();
            gq.delete();
        end else if (disp_valid) begin
            dq.push_back(mk(0, int'(disp_x), int'(disp_y)));
        end else if (g_valid[0] && g_ready[0]) begin
            gq.push_back(mk(1, int'(g_x[0]), int'(g_y[0])));
        end else if (g_valid[1] && g_ready[1]) begin
            gq.push_back(mk(2, int'(g_x[1]), int'(g_y[1])));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        g_valid    = 2'b00;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1;
        repeat (3) step();
        n_chk += 5;
        if (bg_addr !== 19'd0) $display("FAIL rst_addr: got %0d, want 0", bg_addr);
        else n_pass++;
        if (disp_rsp_valid !== 1'b0) $display("FAIL rst_disp_v: got %b, want 0", disp_rsp_valid);
        else n_pass++;
        if (g_rsp_valid !== 2'b00) $display("FAIL rst_g_v: got %b, want 00", g_rsp_valid);
        else n_pass++;
        if (g_rsp_oob !== 1'b0) $display("FAIL rst_oob: got %b, want 0", g_rsp_oob);
        else n_pass++;
        if (g_ready !== 2'b00) $display("FAIL rst_ready: got %b, want 00", g_ready);
        else n_pass++;
        Reset = 1'b0;
        step();
    endtask

    task automatic test_display();
        disp_valid = 1'b1;
        disp_x = 10'd5;
        disp_y = 9'd2;
        step();
        disp_valid = 1'b0;
        n_chk++;
        if (bg_addr !== 19'd1285) $display("FAIL disp_addr: got %0d, want 1285", bg_addr);
        else n_pass++;
        repeat (3) step();
        for (int i = 0; i < 8; i++) begin
            disp_valid = 1'b1;
            disp_x = 10'(100 + i);
            disp_y = 9'd10;
            step();
            n_chk++;
            if (bg_addr !== 19'(6400 + 100 + i))
                $display("FAIL stream_addr: got %0d, want %0d", bg_addr, 6500 + i);
            else n_pass++;
        end
        idle();
        repeat (4) step();
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        g_x[0] = 10'd10; g_y[0] = 9'd20;
        g_x[1] = 10'd30; g_y[1] = 9'd40;
        g_valid = 2'b11;
        want = 2'b01;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_chk++;
            if (g_ready !== want) $display("FAIL rr_grant%0d: got %b, want %b", i, g_ready, want);
            else n_pass++;
            want = {want[0], want[1]};
            step();
        end
        idle();
        repeat (4) step();
    endtask

    task automatic test_disp_priority();
        g_x[0] = 10'd7; g_y[0] = 9'd3;
        g_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            disp_valid = 1'b1;
            disp_x = 10'(200 + i);
            disp_y = 9'd1;
            #1;
            n_chk++;
            if (g_ready !== 2'b00) $display("FAIL prio_block%0d: got %b, want 00", i, g_ready);
            else n_pass++;
            step();
        end
        disp_valid = 1'b0;
        #1;
        n_chk++;
        if (g_ready !== 2'b01) $display("FAIL prio_release: got %b, want 01", g_ready);
        else n_pass++;
        step();
        g_valid = 2'b00;
        n_chk++;
        if (bg_addr !== 19'd1927) $display("FAIL prio_addr: got %0d, want 1927", bg_addr);
        else n_pass++;
        repeat (4) step();
    endtask

    task automatic test_oob();
        g_x[1] = 10'd640; g_y[1] = 9'd0;
        g_valid = 2'b10;
        step();
        g_valid = 2'b00;
        n_chk++;
        if (bg_addr !== 19'd1927) $display("FAIL oob_hold_x: got %0d, want 1927", bg_addr);
        else n_pass++;
        g_x[0] = 10'd639; g_y[0] = 9'd479;
        g_valid = 2'b01;
        step();
        g_valid = 2'b00;
        n_chk++;
        if (bg_addr !== 19'd307199) $display("FAIL max_addr: got %0d, want 307199", bg_addr);
        else n_pass++;
        g_x[1] = 10'd0; g_y[1] = 9'd480;
        g_valid = 2'b10;
        step();
        g_valid = 2'b00;
        n_chk++;
        if (bg_addr !== 19'd307199) $display("FAIL oob_hold_y: got %0d, want 307199", bg_addr);
        else n_pass++;
        repeat (4) step();
    endtask

    task automatic test_reset_midflight();
        int pulses;
        g_x[0] = 10'd1; g_y[0] = 9'd1;
        g_x[1] = 10'd2; g_y[1] = 9'd2;
        g_valid = 2'b11;
        step();
        g_valid = 2'b01;
        step();
        idle();
        Reset = 1'b1;
        step();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (disp_rsp_valid || g_rsp_valid != 2'b00) pulses++;
            step();
            if (i == 1) Reset = 1'b0;
        end
        n_chk++;
        if (pulses !== 0) $display("FAIL rst_drop: got %0d pulses, want 0", pulses);
        else n_pass++;
        g_valid = 2'b11;
        #1;
        n_chk++;
        if (g_ready !== 2'b01) $display("FAIL rst_rr: got %b, want 01", g_ready);
        else n_pass++;
        step();
        idle();
        repeat (4) step();
    endtask

`ifdef BG_ARB_STATS_EN
    task automatic test_stats();
        idle();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        g_x[1] = 10'd50; g_y[1] = 9'd60;
        g_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            disp_valid = 1'b1;
            disp_x = 10'(300 + i);
            disp_y = 9'd5;
            step();
        end
        disp_valid = 1'b0;
        step();
        g_valid = 2'b00;
        step();
        n_chk += 3;
        if (stat_max_wait !== 16'd10) $display("FAIL stat_wait: got %0d, want 10", stat_max_wait);
        else n_pass++;
        if (stat_g_grants[1] !== 16'd1) $display("FAIL stat_g1: got %0d, want 1", stat_g_grants[1]);
        else n_pass++;
        if (stat_g_grants[0] !== 16'd0) $display("FAIL stat_g0: got %0d, want 0", stat_g_grants[0]);
        else n_pass++;
        repeat (4) step();
    endtask
`endif

    initial begin
        test_reset();
        test_display();
        test_round_robin();
        test_disp_priority();
        test_oob();
        test_reset_midflight();
`ifdef BG_ARB_STATS_EN
        test_stats();
`endif
        idle();
        repeat (5) step();
        n_chk += 2;
        if (dq.size() !== 0) $display("FAIL disp_drain: got %0d left, want 0", dq.size());
        else n_pass++;
        if (gq.size() !== 0) $display("FAIL g_drain: got %0d left, want 0", gq.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bg_read_arbiter.md
# bg_read_arbiter

Shares the single synchronous read port of the 640x480, 8-bit-per-pixel background memory between the VGA display fetch path and two game-logic requesters (collision/probe units). It converts (x, y) coordinates to a linear address, enforces display priority, round-robins the game ports, and returns tagged read data after the memory's one-cycle read latency. It sits between the background memory and its consumers; nothing else drives the memory address.

## Interface
Parameters:
- H_RES, 640, pixels per row
- V_RES, 480, rows
- ADDR_W, 19, memory address width
- DATA_W, 8, palette index width
- OOB_INDEX, 8'h00, data returned for out-of-range coordinates

Ports:
- Clk  in  1  system clock, all logic on posedge
- Reset  in  1  synchronous, active-high
- disp_valid  in  1  display fetch request, no backpressure
- disp_x / disp_y  in  10 / 9  display coordinates
- disp_rsp_valid  out  1  display read data valid
- disp_rsp_data  out  DATA_W  display palette index
- g_valid[1:0]  in  2  game request valid, one per port
- g_ready[1:0]  out  2  game request accepted when valid & ready
- g_x[1:0] / g_y[1:0]  in  2x10 / 2x9  game coordinates
- g_rsp_valid[1:0]  out  2  game response valid, one-hot, no backpressure
- g_rsp_data  out  DATA_W  shared game response data
- g_rsp_oob  out  1  response was out of range
- bg_addr  out  ADDR_W  to background memory read_address
- bg_data  in  DATA_W  from background memory data_Out

## Operation
- Address: addr = y*640 + x, computed as (y<<9)+(y<<7)+x, ADDR_W bits, no multiplier. OOB when x >= H_RES or y >= V_RES; OOB requests are still granted a slot, bg_addr holds its previous value, response data forced to OOB_INDEX.
- Arbitration each cycle, one grant max:
  - disp_valid set: display granted, g_ready = 2'b00.
  - Else: round-robin between valid game ports; rr_ptr indicates preferred port; on grant to port k, rr_ptr <= ~k. If only one valid, it is granted regardless of rr_ptr.
  - g_ready is combinational: g_ready[k] = ~disp_valid & g_valid[k] & (port k wins). A valid game request waits with stable coordinates until ready.
- Pipeline: stage 1 registers bg_addr plus tag {port id, oob, valid}; stage 2 registers tag; response outputs driven from stage-2 tag, data muxed from bg_data (or OOB_INDEX).
- Reset: rr_ptr = 0, bg_addr = 0, all tags invalid; disp_rsp_valid, g_rsp_valid, g_rsp_oob = 0, data outputs reflect 0/OOB mux of invalid stage. Reset mid-flight drops in-flight reads; no response appears for them.

## Timing
- Request accepted at edge E0; bg_addr updated at E0; memory samples at E1; response valid in cycle after E1 (latency 2 edges), for exactly one cycle.
- Throughput one read per cycle; back-to-back grants to any mix of ports.
- Display responses return in request order with fixed latency 2; display stream never stalls.
- Game port starves while disp_valid is continuously high; this is by design (display fetch runs only during active video, game ports are served in blanking).

## Configuration
- BG_ARB_STATS_EN defined: adds outputs stat_g_grants[1:0] (2x16, saturating grant counts per game port) and stat_max_wait (16, saturating longest valid-to-ready wait of any game port); cleared by Reset.
- Undefined: those ports and counters do not exist; behaviour otherwise identical.

## Structure
- Package bg_arb_pkg: H_RES, V_RES, coordinate typedefs (bg_x_t 10 bits, bg_y_t 9 bits), bg_addr_t, port-id enum {PORT_DISP, PORT_G0, PORT_G1}, response tag struct.
- Sub-module bg_addr_calc: combinational x,y -> addr + oob; instantiated once on the granted coordinates.

## Test plan
- Display only, (x=5,y=2) -> bg_addr=1285 after E0; disp_rsp_valid two edges later with memory byte at 1285.
- g_valid=2'b11 continuously, disp_valid=0 -> grants alternate G0,G1,G0,G1 starting G0 after reset.
- disp_valid and g_valid[0] same cycle -> g_ready=0, display served; G0 granted first cycle disp_valid drops, coordinates held.
- Game request (x=640,y=0) -> g_rsp_valid one-hot on port, g_rsp_oob=1, g_rsp_data=OOB_INDEX; (639,479) -> addr 307199, oob=0.
- Reset asserted one cycle after two grants -> no rsp_valid pulses afterwards; rr_ptr back to 0.
- With BG_ARB_STATS_EN: hold G1 valid under 10 cycles of display -> stat_max_wait=10, stat_g_grants[1]=1.
